// File: rtl/clk_div_pkg.sv
// Shared helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Divisor value that parks a channel with both outputs low.
  localparam int DIV_OFF = 0;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Number of high cycles in a period of length a: ceil(a/2).
  function automatic logic [31:0] hi_count(input logic [31:0] a);
    return a - (a >> 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active divisor pair, up-counter, registered
// square-wave and tick outputs. New divisors only take over at a period
// boundary (wrap or sync_clr), so a period never gets cut short.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] OFF     = CNT_W'(DIV_OFF);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] shadow_div, act_div, cnt;
  logic [CNT_W-1:0] shadow_nxt, act_nxt, cnt_nxt;
  logic             tick_nxt, clk_nxt;

  function automatic logic [CNT_W-1:0] hi_of(input logic [CNT_W-1:0] a);
    return CNT_W'(hi_count(32'(a)));
  endfunction

  // Next-state decode: disabled, period boundary (wrap or sync_clr), or count.
  always_comb begin
    shadow_nxt = wr_en ? cfg_div : shadow_div;
    act_nxt    = act_div;
    cnt_nxt    = cnt;
    tick_nxt   = 1'b0;
    clk_nxt    = 1'b0;
    if (act_div == OFF) begin
      // A write of N>=1 re-arms the channel so the very next edge wraps.
      if (wr_en && (cfg_div != OFF)) begin
        act_nxt = cfg_div;
        cnt_nxt = cfg_div - ONE;
        clk_nxt = (cnt_nxt < hi_of(cfg_div));
      end else begin
        cnt_nxt = '0;
      end
    end else if (sync_clr || (cnt == act_div - ONE)) begin
      // Same-edge write bypasses the shadow register.
      act_nxt  = shadow_nxt;
      cnt_nxt  = '0;
      tick_nxt = (shadow_nxt != OFF);
      clk_nxt  = (shadow_nxt != OFF);
    end else begin
      cnt_nxt = cnt + ONE;
      clk_nxt = (cnt_nxt < hi_of(act_div));
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shadow_div  <= DEF_DIV;
      act_div     <= DEF_DIV;
      cnt         <= DEF_DIV - ONE;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      shadow_div  <= shadow_nxt;
      act_div     <= act_nxt;
      cnt         <= cnt_nxt;
      clk_out     <= clk_nxt;
      tick        <= tick_nxt;
      cfg_pending <= (shadow_nxt != act_nxt);
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider. Decodes the config
// write onto one channel; out-of-range channel numbers are dropped.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 16,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0] wr_en;

  // Per-channel write strobe; no strobe fires for cfg_ch >= NUM_CH.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in      (clk_in),
      .reset       (reset),
      .sync_clr    (sync_clr),
      .wr_en       (wr_en[g]),
      .cfg_div     (cfg_div),
      .clk_out     (clk_out[g]),
      .tick        (tick[g]),
      .cfg_pending (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi, five channels so cfg_ch can address
// a non-existent channel.
module tb_clk_div_multi;

  localparam int NUM_CH      = 5;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 2;
  localparam int CH_W        = 3;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              sync_clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out, tick, cfg_pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sync_clr    (sync_clr),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Holds reset across one edge and releases it; next edge is edge 1.
  task automatic apply_reset();
    reset = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic write_cyc(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] exp_v;
    reset = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    #2;
    n_vec++; if (clk_out !== '0) begin n_err++; $display("FAIL reset_clk_out got %b expected %b", clk_out, 5'b0); end
    n_vec++; if (tick !== '0) begin n_err++; $display("FAIL reset_tick got %b expected %b", tick, 5'b0); end
    n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL reset_pending got %b expected %b", cfg_pending, 5'b0); end
    cyc();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      exp_v = (e % 2 == 1) ? '1 : '0;
      n_vec++; if (tick !== exp_v) begin n_err++; $display("FAIL reset_run_tick e%0d got %b expected %b", e, tick, exp_v); end
      n_vec++; if (clk_out !== exp_v) begin n_err++; $display("FAIL reset_run_clk e%0d got %b expected %b", e, clk_out, exp_v); end
      n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL reset_run_pend e%0d got %b expected %b", e, cfg_pending, 5'b0); end
    end
  endtask

  task automatic test_write_ch1();
    logic et, ec;
    apply_reset();
    cyc();                       // edge 1
    write_cyc(3'd1, 16'd5);      // edge 2, mid-period of div 2
    n_vec++; if (cfg_pending !== 5'b00010) begin n_err++; $display("FAIL wr1_pend_set got %b expected %b", cfg_pending, 5'b00010); end
    n_vec++; if (tick[1] !== 1'b0 || clk_out[1] !== 1'b0) begin n_err++; $display("FAIL wr1_old_period got t%b c%b expected t0 c0", tick[1], clk_out[1]); end
    for (int e = 3; e <= 13; e++) begin
      cyc();
      et = ((e - 3) % 5 == 0);
      ec = ((e - 3) % 5 < 3);
      n_vec++; if (tick[1] !== et) begin n_err++; $display("FAIL wr1_tick e%0d got %b expected %b", e, tick[1], et); end
      n_vec++; if (clk_out[1] !== ec) begin n_err++; $display("FAIL wr1_clk e%0d got %b expected %b", e, clk_out[1], ec); end
      n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL wr1_pend e%0d got %b expected %b", e, cfg_pending, 5'b0); end
      n_vec++; if (tick[0] !== (e % 2 == 1)) begin n_err++; $display("FAIL wr1_ch0_tick e%0d got %b expected %b", e, tick[0], (e % 2 == 1)); end
    end
  endtask

  task automatic test_disable_ch2();
    logic et, ec;
    apply_reset();
    cyc();                       // edge 1
    write_cyc(3'd2, 16'd0);      // edge 2
    n_vec++; if (cfg_pending !== 5'b00100) begin n_err++; $display("FAIL dis_pend_set got %b expected %b", cfg_pending, 5'b00100); end
    cyc();                       // edge 3: wrap, channel parks
    n_vec++; if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0) begin n_err++; $display("FAIL dis_stop got t%b c%b expected t0 c0", tick[2], clk_out[2]); end
    n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL dis_pend_clr got %b expected %b", cfg_pending, 5'b0); end
    n_vec++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL dis_ch0_tick got %b expected 1", tick[0]); end
    for (int e = 4; e <= 5; e++) begin
      cyc();
      n_vec++; if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0) begin n_err++; $display("FAIL dis_hold e%0d got t%b c%b expected t0 c0", e, tick[2], clk_out[2]); end
    end
    write_cyc(3'd2, 16'd3);      // edge 6: re-arm
    n_vec++; if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0 || cfg_pending !== '0) begin n_err++; $display("FAIL dis_rearm got t%b c%b p%b expected t0 c0 p00000", tick[2], clk_out[2], cfg_pending); end
    for (int e = 7; e <= 12; e++) begin
      cyc();
      et = ((e - 7) % 3 == 0);
      ec = ((e - 7) % 3 < 2);
      n_vec++; if (tick[2] !== et) begin n_err++; $display("FAIL dis_run_tick e%0d got %b expected %b", e, tick[2], et); end
      n_vec++; if (clk_out[2] !== ec) begin n_err++; $display("FAIL dis_run_clk e%0d got %b expected %b", e, clk_out[2], ec); end
    end
  endtask

  task automatic test_sync_clr();
    int divs [NUM_CH] = '{3, 4, 7, 2, 2};
    logic [NUM_CH-1:0] et, ec;
    apply_reset();
    write_cyc(3'd0, 16'd3);      // edge 1: wrap, bypass
    n_vec++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1 || cfg_pending !== '0) begin n_err++; $display("FAIL sync_bypass got t%b c%b p%b expected t1 c1 p00000", tick[0], clk_out[0], cfg_pending); end
    write_cyc(3'd1, 16'd4);      // edge 2
    n_vec++; if (cfg_pending !== 5'b00010) begin n_err++; $display("FAIL sync_pend1 got %b expected %b", cfg_pending, 5'b00010); end
    write_cyc(3'd2, 16'd7);      // edge 3
    n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL sync_pend2 got %b expected %b", cfg_pending, 5'b0); end
    cyc(); cyc();                // edges 4,5
    sync_clr = 1'b1;
    cyc();                       // edge 6
    sync_clr = 1'b0;
    n_vec++; if (tick !== 5'h1F) begin n_err++; $display("FAIL sync_tick_all got %b expected %b", tick, 5'h1F); end
    n_vec++; if (clk_out !== 5'h1F) begin n_err++; $display("FAIL sync_clk_all got %b expected %b", clk_out, 5'h1F); end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      for (int c = 0; c < NUM_CH; c++) begin
        et[c] = (k % divs[c] == 0);
        ec[c] = (k % divs[c] < divs[c] - divs[c] / 2);
      end
      n_vec++; if (tick !== et) begin n_err++; $display("FAIL sync_tick k%0d got %b expected %b", k, tick, et); end
      n_vec++; if (clk_out !== ec) begin n_err++; $display("FAIL sync_clk k%0d got %b expected %b", k, clk_out, ec); end
    end
  endtask

  task automatic test_div1_oor();
    logic [NUM_CH-2:0] et;
    apply_reset();
    write_cyc(3'd0, 16'd1);      // edge 1
    n_vec++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin n_err++; $display("FAIL div1_first got t%b c%b expected t1 c1", tick[0], clk_out[0]); end
    write_cyc(3'd5, 16'd9);      // edge 2, no such channel
    n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL oor5_pend got %b expected %b", cfg_pending, 5'b0); end
    write_cyc(3'd7, 16'd0);      // edge 3
    n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL oor7_pend got %b expected %b", cfg_pending, 5'b0); end
    for (int e = 4; e <= 7; e++) begin
      cyc();
      et = (e % 2 == 1) ? '1 : '0;
      n_vec++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin n_err++; $display("FAIL div1_hold e%0d got t%b c%b expected t1 c1", e, tick[0], clk_out[0]); end
      n_vec++; if (tick[4:1] !== et) begin n_err++; $display("FAIL oor_others e%0d got %b expected %b", e, tick[4:1], et); end
    end
  endtask

  task automatic test_back_to_back();
    logic et, ec, ep;
    apply_reset();
    write_cyc(3'd1, 16'd6);      // edge 1: bypass to 6
    write_cyc(3'd1, 16'd5);      // edge 2
    write_cyc(3'd1, 16'd3);      // edge 3: last write wins
    n_vec++; if (cfg_pending[1] !== 1'b1) begin n_err++; $display("FAIL b2b_pend got %b expected 1", cfg_pending[1]); end
    for (int e = 4; e <= 13; e++) begin
      cyc();
      et = (e >= 7) && ((e - 7) % 3 == 0);
      ec = (e >= 7) && ((e - 7) % 3 < 2);
      ep = (e < 7);
      n_vec++; if (tick[1] !== et) begin n_err++; $display("FAIL b2b_tick e%0d got %b expected %b", e, tick[1], et); end
      n_vec++; if (clk_out[1] !== ec) begin n_err++; $display("FAIL b2b_clk e%0d got %b expected %b", e, clk_out[1], ec); end
      n_vec++; if (cfg_pending[1] !== ep) begin n_err++; $display("FAIL b2b_pend e%0d got %b expected %b", e, cfg_pending[1], ep); end
    end
  endtask

  task automatic test_reset_mid();
    logic e_odd;
    apply_reset();
    write_cyc(3'd3, 16'd6);      // edge 1: bypass to 6
    write_cyc(3'd3, 16'd4);      // edge 2: pending
    cyc();                       // edge 3
    n_vec++; if (cfg_pending !== 5'b01000) begin n_err++; $display("FAIL rmid_pend got %b expected %b", cfg_pending, 5'b01000); end
    n_vec++; if (tick !== 5'b10111) begin n_err++; $display("FAIL rmid_tick_pre got %b expected %b", tick, 5'b10111); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (clk_out !== '0 || tick !== '0 || cfg_pending !== '0) begin n_err++; $display("FAIL rmid_async got c%b t%b p%b expected all 0", clk_out, tick, cfg_pending); end
    cyc();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cyc();
      e_odd = (e % 2 == 1);
      n_vec++; if (tick[3] !== e_odd || clk_out[3] !== e_odd) begin n_err++; $display("FAIL rmid_ch3 e%0d got t%b c%b expected %b", e, tick[3], clk_out[3], e_odd); end
      n_vec++; if (cfg_pending !== '0) begin n_err++; $display("FAIL rmid_pend_after e%0d got %b expected %b", e, cfg_pending, 5'b0); end
    end
  endtask

  initial begin
    test_reset();
    test_write_ch1();
    test_disable_ch2();
    test_sync_clr();
    test_div1_oor();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
